// File: rtl/ftsd_pkg.sv
// Shared definitions for the four-digit BCD stopwatch: digit code width,
// the all-off digit code and the run-control state encoding.
package ftsd_pkg;

  localparam int DIGIT_W = 5;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // A BCD nibble maps straight onto the low bits of a digit code.
  function automatic logic [DIGIT_W-1:0] bcd_code(input logic [3:0] q);
    return {1'b0, q};
  endfunction

endpackage

// File: rtl/ftsd_stopwatch_bcd_digit.sv
// One decade of the stopwatch count: wraps 9->0 up or 0->9 down and
// passes the step on to the next decade when it wraps.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       step_in,
  input  logic       dir,
  output logic [3:0] q,
  output logic       step_out
);

  // NOTE: sequential state uses <= so every decade samples the old count
  // on the same edge; blocking here would let one digit see another's new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (step_in) begin
      if (dir) q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
      else     q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
    end
  end

  assign step_out = step_in && (dir ? (q == 4'd0) : (q == 4'd9));

endmodule

// File: rtl/ftsd_stopwatch.sv
// Four-digit BCD up/down stopwatch: run/pause/clear control, count prescaler,
// leading-zero blanking and the free-running scan phase for the display mux.
module ftsd_stopwatch #(
  parameter int                            CNT_DIV    = 10_000_000,
  parameter int                            SCAN_BITS  = 17,
  parameter bit                            LZB        = 1'b1,
  parameter logic [ftsd_pkg::DIGIT_W-1:0]  BLANK_CODE = ftsd_pkg::BLANK_CODE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_stop,
  input  logic                           clear,
  input  logic                           dir,
  output logic [ftsd_pkg::DIGIT_W-1:0]   digit0,
  output logic [ftsd_pkg::DIGIT_W-1:0]   digit1,
  output logic [ftsd_pkg::DIGIT_W-1:0]   digit2,
  output logic [ftsd_pkg::DIGIT_W-1:0]   digit3,
  output logic [1:0]                     ftsd_ctl_en,
  output logic                           running,
  output logic                           wrap
);

  import ftsd_pkg::*;

  localparam int PRE_W = (CNT_DIV > 2) ? $clog2(CNT_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CNT_DIV - 1);

  state_t               state, state_nx;
  logic [PRE_W-1:0]     presc;
  logic [SCAN_BITS-1:0] scan;
  logic                 step;
  logic [4:0]           chain;
  logic [3:0][3:0]      bcd;
  logic [DIGIT_W-1:0]   code [4];
  logic                 lead;

  // Run control: clear overrides start_stop in the same cycle.
  // NOTE: every combinational output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else if (start_stop) begin
      case (state)
        IDLE:    state_nx = RUN;
        RUN:     state_nx = PAUSE;
        PAUSE:   state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign step = (state == RUN) && (presc == PRE_LAST) && !clear;

  // Prescaler keeps its partial period through PAUSE so resume is seamless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clear || state == IDLE) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= step ? '0 : presc + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) scan <= '0;
    else     scan <= scan + SCAN_BITS'(1);
  end

  // Units (index 3) take the prescaler step; each decade feeds the one to its left.
  assign chain[4] = step;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (clear),
      .step_in  (chain[i+1]),
      .dir      (dir),
      .q        (bcd[i]),
      .step_out (chain[i])
    );
  end

  // A step leaving the thousands decade is a full-range wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= chain[0];
  end

  always_comb begin
    lead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      code[i] = bcd_code(bcd[i]);
      if (LZB && lead && bcd[i] == 4'd0) code[i] = BLANK_CODE;
      else                               lead    = 1'b0;
    end
    code[3] = bcd_code(bcd[3]);
  end

  assign digit0      = code[0];
  assign digit1      = code[1];
  assign digit2      = code[2];
  assign digit3      = code[3];
  assign ftsd_ctl_en = scan[SCAN_BITS-1 -: 2];
  assign running     = (state == RUN);

endmodule

// File: tb/tb_ftsd_stopwatch.sv
// Scoreboard bench for ftsd_stopwatch with CNT_DIV=4, SCAN_BITS=4, LZB=1:
// stimulus queues expected display states per cycle, a negedge monitor compares.
module tb_ftsd_stopwatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       dir = 1'b0;
  logic [4:0] digit0, digit1, digit2, digit3;
  logic [1:0] ftsd_ctl_en;
  logic       running, wrap;

  ftsd_stopwatch #(
    .CNT_DIV    (4),
    .SCAN_BITS  (4),
    .LZB        (1'b1),
    .BLANK_CODE (5'd31)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_stop  (start_stop),
    .clear       (clear),
    .dir         (dir),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .ftsd_ctl_en (ftsd_ctl_en),
    .running     (running),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference scan phase: free-running, cleared only by rst.
  logic [3:0] scan_m;
  always @(posedge clk or posedge rst) begin
    if (rst) scan_m <= 4'd0;
    else     scan_m <= scan_m + 4'd1;
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [19:0] digits;
    logic        running;
    logic        wrap;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expect_at(input int c, input string name,
                           input logic [4:0] d0, input logic [4:0] d1,
                           input logic [4:0] d2, input logic [4:0] d3,
                           input logic run, input logic wr);
    exp_t e;
    e.cyc     = c;
    e.name    = name;
    e.digits  = {d0, d1, d2, d3};
    e.running = run;
    e.wrap    = wr;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: the display is presented every cycle; compare whatever is due.
  always @(negedge clk) begin
    check("scan_phase", 32'(ftsd_ctl_en), 32'(scan_m[3:2]));
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d not compared, now cycle %0d", e.name, e.cyc, cyc);
      end else begin
        check({e.name, "/digits"},  32'({digit0, digit1, digit2, digit3}), 32'(e.digits));
        check({e.name, "/running"}, 32'(running), 32'(e.running));
        check({e.name, "/wrap"},    32'(wrap),    32'(e.wrap));
      end
    end
  end

  int b;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: idle after reset, leading zeros blanked, scan phase free-running
    b = cyc;
    expect_at(b,      "t1_reset", 31, 31, 31, 0, 1'b0, 1'b0);
    expect_at(b + 4,  "t1_idle4", 31, 31, 31, 0, 1'b0, 1'b0);
    expect_at(b + 12, "t1_idle12", 31, 31, 31, 0, 1'b0, 1'b0);
    expect_at(b + 19, "t1_idle19", 31, 31, 31, 0, 1'b0, 1'b0);
    tick(20);

    // 2: count up, one step every 4 cycles after the start edge
    start_stop = 1'b1; tick(1); start_stop = 1'b0;
    b = cyc;
    expect_at(b,      "t2_start",  31, 31, 31, 0, 1'b1, 1'b0);
    expect_at(b + 3,  "t2_before1", 31, 31, 31, 0, 1'b1, 1'b0);
    expect_at(b + 4,  "t2_step1",  31, 31, 31, 1, 1'b1, 1'b0);
    expect_at(b + 35, "t2_count8", 31, 31, 31, 8, 1'b1, 1'b0);
    expect_at(b + 36, "t2_count9", 31, 31, 31, 9, 1'b1, 1'b0);
    expect_at(b + 39, "t2_hold9",  31, 31, 31, 9, 1'b1, 1'b0);
    expect_at(b + 40, "t2_count10", 31, 31, 1, 0, 1'b1, 1'b0);
    tick(40);

    clear = 1'b1; tick(1); clear = 1'b0;
    expect_at(cyc, "t3_cleared", 31, 31, 31, 0, 1'b0, 1'b0);

    // 3: down from 0000 wraps to 9999, then up from 9999 wraps to 0000
    dir = 1'b1; start_stop = 1'b1; tick(1); start_stop = 1'b0;
    b = cyc;
    expect_at(b + 3, "t3_down_pre",  31, 31, 31, 0, 1'b1, 1'b0);
    expect_at(b + 4, "t3_down_wrap",  9,  9,  9, 9, 1'b1, 1'b1);
    expect_at(b + 5, "t3_down_once",  9,  9,  9, 9, 1'b1, 1'b0);
    tick(5);
    dir = 1'b0;
    expect_at(b + 7, "t3_up_pre",     9,  9,  9, 9, 1'b1, 1'b0);
    expect_at(b + 8, "t3_up_wrap",   31, 31, 31, 0, 1'b1, 1'b1);
    expect_at(b + 9, "t3_up_once",   31, 31, 31, 0, 1'b1, 1'b0);
    tick(4);

    // 4: pause with the prescaler 2 into its period, resume needs 2 more cycles
    start_stop = 1'b1; tick(1); start_stop = 1'b0;
    b = cyc;
    expect_at(b,      "t4_paused",   31, 31, 31, 0, 1'b0, 1'b0);
    expect_at(b + 25, "t4_paused25", 31, 31, 31, 0, 1'b0, 1'b0);
    expect_at(b + 50, "t4_paused50", 31, 31, 31, 0, 1'b0, 1'b0);
    tick(50);
    start_stop = 1'b1; tick(1); start_stop = 1'b0;
    b = cyc;
    expect_at(b,     "t4_resumed", 31, 31, 31, 0, 1'b1, 1'b0);
    expect_at(b + 1, "t4_wait",    31, 31, 31, 0, 1'b1, 1'b0);
    expect_at(b + 2, "t4_step",    31, 31, 31, 1, 1'b1, 1'b0);
    tick(2);

    // 5: clear and start_stop together while running: clear wins
    clear = 1'b1; start_stop = 1'b1; tick(1); clear = 1'b0; start_stop = 1'b0;
    expect_at(cyc,     "t5_clear", 31, 31, 31, 0, 1'b0, 1'b0);
    expect_at(cyc + 6, "t5_idle",  31, 31, 31, 0, 1'b0, 1'b0);
    tick(6);

    // 6: async reset mid-period with units=7
    start_stop = 1'b1; tick(1); start_stop = 1'b0;
    b = cyc;
    expect_at(b + 28, "t6_units7", 31, 31, 31, 7, 1'b1, 1'b0);
    tick(29);
    rst = 1'b1;
    expect_at(cyc, "t6_async_rst", 31, 31, 31, 0, 1'b0, 1'b0);
    tick(2);
    rst = 1'b0;
    expect_at(cyc + 3, "t6_after_rst", 31, 31, 31, 0, 1'b0, 1'b0);
    tick(4);

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick(1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never compared", e.name, e.cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
